food_spawner: RTL and testbench
===============================

// Module: food_spawner
// PURPOSE
//  Picks a free grid cell for the next snake food item and returns its cell and pixel
//  coordinates. Sits between game control (spawn request) and the snake body store
//  (occupancy lookup). Free-running LFSR draws random candidates; occupied candidates
//  are retried up to MAX_TRIES times, then a linear scan guarantees a free cell or
//  reports a full grid.
// PARAMETERS
//  GAME_SIZE  25        cell edge in pixels
//  GRID_W     76        grid width in cells (>=2, <=128)
//  GRID_H     42        grid height in cells (>=2, <=128)
//  X_ORIGIN   0         pixel x of cell column 0
//  Y_ORIGIN   0         pixel y of cell row 0
//  MAX_TRIES  8         random draws before falling back to scan (>=1, <=255)
//  LFSR_SEED  16'hACE1  LFSR reset value; 0 is replaced by 16'h0001
// PORTS
//  clock           in   1   system clock, all logic posedge
//  reset           in   1   synchronous, active-high
//  spawn_req       in   1   request new food position; sampled only in IDLE
//  busy            out  1   search in progress
//  query_x         out  7   cell column presented to occupancy store
//  query_y         out  7   cell row presented to occupancy store
//  query_occupied  in   1   occupancy of (query_x,query_y), valid 1 cycle after query
//  food_valid      out  1   1-cycle pulse: new position on cell_/rand_ outputs
//  grid_full       out  1   1-cycle pulse: no free cell exists
//  cell_x          out  7   chosen column, held until next food_valid
//  cell_y          out  7   chosen row, held until next food_valid
//  rand_x          out  12  X_ORIGIN + cell_x*GAME_SIZE, held with cell_x
//  rand_y          out  11  Y_ORIGIN + cell_y*GAME_SIZE, held with cell_y
// BEHAVIOUR
//  - Reset: state IDLE, lfsr=LFSR_SEED, try/scan counters 0; busy, food_valid,
//    grid_full, query_*, cell_*, rand_* all 0. Reset mid-search aborts, no pulse.
//  - LFSR: 16-bit Galois, mask 16'hB400, advances every cycle incl. IDLE; never 0.
//  - Candidate: cx=(lfsr[15:8]*GRID_W)>>8, cy=(lfsr[7:0]*GRID_H)>>8; always in range.
//  - States: IDLE, LOOKUP, CHECK.
//    IDLE: spawn_req=1 -> load query from candidate, tries=1, mode=RANDOM, busy=1, LOOKUP.
//    LOOKUP: store reads query (1 cycle) -> CHECK.
//    CHECK (samples query_occupied):
//     free -> cell_*<=query_*, rand_* updated, food_valid=1, busy=0, IDLE.
//     occupied, RANDOM, tries<MAX_TRIES -> new candidate, tries+1, LOOKUP.
//     occupied, RANDOM, tries==MAX_TRIES -> mode=SCAN, scanned=1, query=next cell, LOOKUP.
//     occupied, SCAN, scanned<GRID_W*GRID_H -> query=next cell, scanned+1, LOOKUP.
//     occupied, SCAN, scanned==GRID_W*GRID_H -> grid_full=1, busy=0, cell_* unchanged, IDLE.
//  - Next cell: x+1; x==GRID_W-1 -> x=0,y+1; (GRID_W-1,GRID_H-1) wraps to (0,0).
//    Scan starts after last random candidate and visits every cell exactly once.
//  - Latency: req sampled at edge k -> food_valid high after edge k+2 if first draw free;
//    each further candidate +2 cycles. Full grid: grid_full after 2*(MAX_TRIES+W*H) edges.
//  - spawn_req ignored while busy and in the cycle food_valid/grid_full is high;
//    a held spawn_req restarts one cycle after completion.
//  - query_* change only on LOOKUP entry; stable through CHECK.
//  - Pixel math: products widened to 12/11 bits; params sized so max fits.
// TESTING (bench uses GAME_SIZE=25, GRID_W=4, GRID_H=3, MAX_TRIES=4 unless noted)
//  1 reset 2 cycles mid-run -> all outputs 0, busy 0, lfsr==LFSR_SEED next cycle.
//  2 empty grid, 1-cycle spawn_req -> food_valid 2 edges later, cell_x<4, cell_y<3,
//    rand_x==25*cell_x, rand_y==25*cell_y; matches LFSR reference model.
//  3 only cell (3,2) free -> food_valid, cell=(3,2), rand_x=75, rand_y=50, <=32 cycles.
//  4 all 12 cells occupied -> grid_full exactly 32 edges after req, no food_valid, each
//    cell queried once in scan phase, cell_* retain previous values.
//  5 reset asserted 3 cycles after spawn_req -> busy 0 next edge, no pulse ever follows.
//  6 spawn_req held high 100 cycles, empty grid, defaults -> food_valid every 3 cycles,
//    extra reqs during busy ignored; all cells <(76,42), rand_x<=1875, rand_y<=1025.

Source files
------------

// File: rtl/food_spawner.sv
// Chooses a free grid cell for the next food item: random LFSR draws first, then a
// wrapping linear scan that either finds a free cell or reports a completely full grid.
module food_spawner #(
    parameter int unsigned GAME_SIZE = 25,
    parameter int unsigned GRID_W    = 76,
    parameter int unsigned GRID_H    = 42,
    parameter int unsigned X_ORIGIN  = 0,
    parameter int unsigned Y_ORIGIN  = 0,
    parameter int unsigned MAX_TRIES = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        spawn_req,
    output logic        busy,
    output logic [6:0]  query_x,
    output logic [6:0]  query_y,
    input  logic        query_occupied,
    output logic        food_valid,
    output logic        grid_full,
    output logic [6:0]  cell_x,
    output logic [6:0]  cell_y,
    output logic [11:0] rand_x,
    output logic [10:0] rand_y
);

    typedef enum logic [1:0] {IDLE, LOOKUP, CHECK} state_t;

    localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [14:0] CELLS     = 15'(GRID_W * GRID_H);
    localparam logic [6:0]  LAST_X    = 7'(GRID_W - 1);
    localparam logic [6:0]  LAST_Y    = 7'(GRID_H - 1);

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  tries_q, tries_d;
    logic [14:0] scanned_q, scanned_d;
    logic        scan_q, scan_d;
    logic        busy_q, busy_d;
    logic        food_valid_q, food_valid_d;
    logic        grid_full_q, grid_full_d;
    logic [6:0]  query_x_q, query_x_d, query_y_q, query_y_d;
    logic [6:0]  cell_x_q, cell_x_d, cell_y_q, cell_y_d;
    logic [11:0] rand_x_q, rand_x_d;
    logic [10:0] rand_y_q, rand_y_d;

    logic [6:0]  cand_x, cand_y;
    logic [6:0]  next_x, next_y;

    // Scaling an 8-bit random fraction by the grid size keeps candidates in range without a modulo.
    assign cand_x = 7'((32'(lfsr_q[15:8]) * GRID_W) >> 8);
    assign cand_y = 7'((32'(lfsr_q[7:0])  * GRID_H) >> 8);

    always_comb begin
        next_x = query_x_q + 7'd1;
        next_y = query_y_q;
        if (query_x_q == LAST_X) begin
            next_x = 7'd0;
            next_y = (query_y_q == LAST_Y) ? 7'd0 : query_y_q + 7'd1;
        end
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case leaves a latch.
        state_d      = state_q;
        lfsr_d       = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        tries_d      = tries_q;
        scanned_d    = scanned_q;
        scan_d       = scan_q;
        busy_d       = busy_q;
        food_valid_d = 1'b0;
        grid_full_d  = 1'b0;
        query_x_d    = query_x_q;
        query_y_d    = query_y_q;
        cell_x_d     = cell_x_q;
        cell_y_d     = cell_y_q;
        rand_x_d     = rand_x_q;
        rand_y_d     = rand_y_q;

        unique case (state_q)
            IDLE: begin
                if (spawn_req) begin
                    query_x_d = cand_x;
                    query_y_d = cand_y;
                    tries_d   = 8'd1;
                    scan_d    = 1'b0;
                    scanned_d = 15'd0;
                    busy_d    = 1'b1;
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: state_d = CHECK;
            CHECK: begin
                state_d = LOOKUP;
                if (!query_occupied) begin
                    cell_x_d     = query_x_q;
                    cell_y_d     = query_y_q;
                    rand_x_d     = 12'(X_ORIGIN + 32'(query_x_q) * GAME_SIZE);
                    rand_y_d     = 11'(Y_ORIGIN + 32'(query_y_q) * GAME_SIZE);
                    food_valid_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end else if (!scan_q && tries_q < 8'(MAX_TRIES)) begin
                    query_x_d = cand_x;
                    query_y_d = cand_y;
                    tries_d   = tries_q + 8'd1;
                end else if (!scan_q) begin
                    query_x_d = next_x;
                    query_y_d = next_y;
                    scan_d    = 1'b1;
                    scanned_d = 15'd1;
                end else if (scanned_q < CELLS) begin
                    query_x_d = next_x;
                    query_y_d = next_y;
                    scanned_d = scanned_q + 15'd1;
                end else begin
                    grid_full_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; every register, including the LFSR, is reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            lfsr_q       <= SEED;
            tries_q      <= '0;
            scanned_q    <= '0;
            scan_q       <= 1'b0;
            busy_q       <= 1'b0;
            food_valid_q <= 1'b0;
            grid_full_q  <= 1'b0;
            query_x_q    <= '0;
            query_y_q    <= '0;
            cell_x_q     <= '0;
            cell_y_q     <= '0;
            rand_x_q     <= '0;
            rand_y_q     <= '0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            tries_q      <= tries_d;
            scanned_q    <= scanned_d;
            scan_q       <= scan_d;
            busy_q       <= busy_d;
            food_valid_q <= food_valid_d;
            grid_full_q  <= grid_full_d;
            query_x_q    <= query_x_d;
            query_y_q    <= query_y_d;
            cell_x_q     <= cell_x_d;
            cell_y_q     <= cell_y_d;
            rand_x_q     <= rand_x_d;
            rand_y_q     <= rand_y_d;
        end
    end

    assign busy       = busy_q;
    assign food_valid = food_valid_q;
    assign grid_full  = grid_full_q;
    assign query_x    = query_x_q;
    assign query_y    = query_y_q;
    assign cell_x     = cell_x_q;
    assign cell_y     = cell_y_q;
    assign rand_x     = rand_x_q;
    assign rand_y     = rand_y_q;

endmodule

// File: tb/tb_food_spawner.sv
// Bench for food_spawner: a 4x3 grid instance with a registered occupancy store and a
// default-size instance on an empty grid, both scored against an LFSR reference model.
module tb_food_spawner;

    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        bit is_full;
        int cx;
        int cy;
        int rx;
        int ry;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // 4x3 instance
    logic        spawn_req = 1'b0;
    logic        busy, query_occupied, food_valid, grid_full;
    logic [6:0]  query_x, query_y, cell_x, cell_y;
    logic [11:0] rand_x;
    logic [10:0] rand_y;
    bit          occ [12];

    // default-size instance, always empty grid
    logic        spawn_req2 = 1'b0;
    logic        busy2, food_valid2, grid_full2;
    logic        query_occupied2 = 1'b0;
    logic [6:0]  query_x2, query_y2, cell_x2, cell_y2;
    logic [11:0] rand_x2;
    logic [10:0] rand_y2;

    logic [15:0] model_lfsr;
    exp_t        sb1 [$];
    exp_t        sb2 [$];
    exp_t        e1, e2;
    int          vectors = 0;
    int          miscompares = 0;

    food_spawner #(.GAME_SIZE(25), .GRID_W(4), .GRID_H(3), .MAX_TRIES(4)) dut (
        .clock(clk), .reset(reset), .spawn_req(spawn_req), .busy(busy),
        .query_x(query_x), .query_y(query_y), .query_occupied(query_occupied),
        .food_valid(food_valid), .grid_full(grid_full), .cell_x(cell_x), .cell_y(cell_y),
        .rand_x(rand_x), .rand_y(rand_y)
    );

    food_spawner dut2 (
        .clock(clk), .reset(reset), .spawn_req(spawn_req2), .busy(busy2),
        .query_x(query_x2), .query_y(query_y2), .query_occupied(query_occupied2),
        .food_valid(food_valid2), .grid_full(grid_full2), .cell_x(cell_x2), .cell_y(cell_y2),
        .rand_x(rand_x2), .rand_y(rand_y2)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int cand_x(input logic [15:0] s, input int w);
        return (int'(s[15:8]) * w) >> 8;
    endfunction

    function automatic int cand_y(input logic [15:0] s, input int h);
        return (int'(s[7:0]) * h) >> 8;
    endfunction

    always @(posedge clk) begin
        model_lfsr     <= reset ? SEED : lfsr_step(model_lfsr);
        query_occupied <= (query_x < 7'd4 && query_y < 7'd3) ? occ[int'(query_y) * 4 + int'(query_x)] : 1'b1;
    end

    always @(negedge clk) begin
        if (!reset && (food_valid || grid_full)) begin
            vectors++;
            if (sb1.size() == 0) begin
                miscompares++;
                $display("FAIL dut_unexpected_pulse: got food_valid=%b grid_full=%b, required no pulse", food_valid, grid_full);
            end else begin
                e1 = sb1.pop_front();
                if (grid_full !== e1.is_full || food_valid !== !e1.is_full || cell_x !== 7'(e1.cx) ||
                    cell_y !== 7'(e1.cy) || rand_x !== 12'(e1.rx) || rand_y !== 11'(e1.ry)) begin
                    miscompares++;
                    $display("FAIL dut_result: got full=%b cell=(%0d,%0d) pix=(%0d,%0d), required full=%b cell=(%0d,%0d) pix=(%0d,%0d)",
                             grid_full, cell_x, cell_y, rand_x, rand_y, e1.is_full, e1.cx, e1.cy, e1.rx, e1.ry);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && (food_valid2 || grid_full2)) begin
            vectors++;
            if (sb2.size() == 0) begin
                miscompares++;
                $display("FAIL dut2_unexpected_pulse: got food_valid=%b grid_full=%b, required no pulse", food_valid2, grid_full2);
            end else begin
                e2 = sb2.pop_front();
                if (grid_full2 !== 1'b0 || cell_x2 !== 7'(e2.cx) || cell_y2 !== 7'(e2.cy) ||
                    rand_x2 !== 12'(e2.rx) || rand_y2 !== 11'(e2.ry)) begin
                    miscompares++;
                    $display("FAIL dut2_result: got full=%b cell=(%0d,%0d) pix=(%0d,%0d), required cell=(%0d,%0d) pix=(%0d,%0d)",
                             grid_full2, cell_x2, cell_y2, rand_x2, rand_y2, e2.cx, e2.cy, e2.rx, e2.ry);
                end
            end
        end
    end

    task automatic set_occ(input bit all_value);
        for (int i = 0; i < 12; i++) occ[i] = all_value;
    endtask

    task automatic push1(input logic [15:0] l);
        exp_t e;
        e.is_full = 1'b0;
        e.cx = cand_x(l, 4);
        e.cy = cand_y(l, 3);
        e.rx = 25 * e.cx;
        e.ry = 25 * e.cy;
        sb1.push_back(e);
    endtask

    task automatic test_reset;
        set_occ(1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, food_valid, grid_full, query_x, query_y, cell_x, cell_y, rand_x, rand_y} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b q=(%0d,%0d) cell=(%0d,%0d) pix=(%0d,%0d), required all 0",
                     busy, query_x, query_y, cell_x, cell_y, rand_x, rand_y);
        end
        reset = 1'b0;
        set_occ(1'b1);
        spawn_req = 1'b1;
        @(negedge clk);
        spawn_req = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_midrun: got %b, required 1", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, food_valid, grid_full, query_x, query_y} !== '0) begin
            miscompares++;
            $display("FAIL reset_midrun: got busy=%b fv=%b gf=%b q=(%0d,%0d), required all 0",
                     busy, food_valid, grid_full, query_x, query_y);
        end
        @(negedge clk);
        reset = 1'b0;
        set_occ(1'b0);
        spawn_req = 1'b1;
        push1(SEED);
        @(negedge clk);
        spawn_req = 1'b0;
        vectors++;
        if (query_x !== 7'(cand_x(SEED, 4)) || query_y !== 7'(cand_y(SEED, 3))) begin
            miscompares++;
            $display("FAIL seed_candidate: got (%0d,%0d), required (%0d,%0d)",
                     query_x, query_y, cand_x(SEED, 4), cand_y(SEED, 3));
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (food_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL seed_food_valid: got %b, required 1", food_valid);
        end
    endtask

    task automatic test_random;
        set_occ(1'b0);
        for (int t = 0; t < 4; t++) begin
            repeat (t * 3 + 1) @(negedge clk);
            push1(model_lfsr);
            spawn_req = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                spawn_req = 1'b0;
                vectors++;
                if (food_valid !== (c == 2)) begin
                    miscompares++;
                    $display("FAIL random_latency: edge %0d got food_valid=%b, required %b", c, food_valid, c == 2);
                end
            end
        end
    endtask

    task automatic test_one_free;
        int waited;
        exp_t e;
        set_occ(1'b1);
        occ[11] = 1'b0;
        e.is_full = 1'b0; e.cx = 3; e.cy = 2; e.rx = 75; e.ry = 50;
        sb1.push_back(e);
        @(negedge clk);
        spawn_req = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            spawn_req = 1'b0;
            waited++;
        end while (!food_valid && !grid_full && waited < 40);
        vectors++;
        if (food_valid !== 1'b1 || waited > 32) begin
            miscompares++;
            $display("FAIL one_free_latency: got food_valid=%b after %0d edges, required 1 within 32", food_valid, waited);
        end
    endtask

    task automatic test_full;
        exp_t e;
        int   ex [16];
        int   ey [16];
        int   tally [12];
        set_occ(1'b1);
        for (int i = 0; i < 12; i++) tally[i] = 0;
        e.is_full = 1'b1; e.cx = 3; e.cy = 2; e.rx = 75; e.ry = 50;
        sb1.push_back(e);
        @(negedge clk);
        spawn_req = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) begin
                if (i < 8) begin
                    ex[i / 2] = cand_x(model_lfsr, 4);
                    ey[i / 2] = cand_y(model_lfsr, 3);
                end else begin
                    ex[i / 2] = (ex[i / 2 - 1] == 3) ? 0 : ex[i / 2 - 1] + 1;
                    ey[i / 2] = (ex[i / 2 - 1] == 3) ? ((ey[i / 2 - 1] == 2) ? 0 : ey[i / 2 - 1] + 1) : ey[i / 2 - 1];
                end
            end
            @(negedge clk);
            spawn_req = 1'b0;
            if (i % 2 == 0) begin
                vectors++;
                if (query_x !== 7'(ex[i / 2]) || query_y !== 7'(ey[i / 2])) begin
                    miscompares++;
                    $display("FAIL full_query_%0d: got (%0d,%0d), required (%0d,%0d)", i / 2, query_x, query_y, ex[i / 2], ey[i / 2]);
                end
                if (i >= 8 && query_x < 7'd4 && query_y < 7'd3) tally[int'(query_y) * 4 + int'(query_x)]++;
            end
            if (grid_full || food_valid) begin
                vectors++;
                miscompares++;
                $display("FAIL full_early_pulse: got pulse after edge %0d, required none before edge 32", i);
            end
        end
        @(negedge clk);
        vectors++;
        if (grid_full !== 1'b1) begin
            miscompares++;
            $display("FAIL full_timing: got grid_full=%b after edge 32, required 1", grid_full);
        end
        for (int c = 0; c < 12; c++) begin
            vectors++;
            if (tally[c] != 1) begin
                miscompares++;
                $display("FAIL scan_coverage cell %0d: got %0d visits, required 1", c, tally[c]);
            end
        end
    endtask

    task automatic test_reset_abort;
        int pulses;
        set_occ(1'b1);
        spawn_req = 1'b1;
        @(negedge clk);
        spawn_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_busy: got %b, required 0", busy);
        end
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (food_valid || grid_full) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL abort_pulses: got %0d, required 0", pulses);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        spawn_req2 = 1'b1;
        for (int i = 0; i < 99; i++) begin
            if (i % 3 == 0) begin
                e.is_full = 1'b0;
                e.cx = cand_x(model_lfsr, 76);
                e.cy = cand_y(model_lfsr, 42);
                e.rx = 25 * e.cx;
                e.ry = 25 * e.cy;
                sb2.push_back(e);
            end
            @(negedge clk);
            vectors++;
            if (food_valid2 !== (i % 3 == 2)) begin
                miscompares++;
                $display("FAIL b2b_cadence: after edge %0d got food_valid=%b, required %b", i, food_valid2, i % 3 == 2);
            end
            if (food_valid2 && (cell_x2 >= 7'd76 || cell_y2 >= 7'd42 || rand_x2 > 12'd1875 || rand_y2 > 11'd1025)) begin
                vectors++;
                miscompares++;
                $display("FAIL b2b_range: got cell=(%0d,%0d) pix=(%0d,%0d), required within grid", cell_x2, cell_y2, rand_x2, rand_y2);
            end
        end
        spawn_req2 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_random();
        test_one_free();
        test_full();
        test_reset_abort();
        test_back_to_back();
        vectors++;
        if (sb1.size() != 0 || sb2.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending, required 0/0", sb1.size(), sb2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
